// File: rtl/edge_event_monitor.sv
// Edge event monitor: detects rising/falling edges on sig_in and queues one {rise, fall} record per active cycle.
// Optional macro EDGE_MON_DROP_CNT_EN adds a saturating 8-bit drop_cnt output.
module edge_event_monitor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic [WIDTH-1:0]         sig_in,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [WIDTH-1:0]         evt_rise,
  output logic [WIDTH-1:0]         evt_fall,
  output logic [$clog2(DEPTH):0]   occupancy,
  input  logic                     ovf_clr,
  output logic                     overflow
`ifdef EDGE_MON_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned REC_W = 2 * WIDTH;

  logic [WIDTH-1:0] prev;
  logic             armed;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [REC_W-1:0] mem [DEPTH];

  logic [WIDTH-1:0] rise, fall;
  logic [REC_W-1:0] rec;
  logic             edge_hit, pop, full, push, drop;
  logic [PTR_W-1:0] wr_ptr_n, rd_ptr_n;
  logic [CNT_W-1:0] count_n;
  logic             valid_n, overflow_n;
  logic [WIDTH-1:0] rise_n, fall_n;
`ifdef EDGE_MON_DROP_CNT_EN
  logic [7:0]       drop_cnt_n;
`endif

  // Next-state for edge detection, FIFO pointers and the registered head view
  always_comb begin
    rise       = sig_in & ~prev;
    fall       = ~sig_in & prev;
    rec        = {rise, fall};
    edge_hit   = armed & en & (|(rise | fall));
    pop        = (occupancy != CNT_W'(0)) & evt_ready;
    full       = (occupancy == CNT_W'(DEPTH));
    push       = edge_hit & (~full | pop);
    drop       = edge_hit & full & ~pop;
    wr_ptr_n   = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_n   = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_n    = occupancy + CNT_W'(push) - CNT_W'(pop);
    valid_n    = (count_n != CNT_W'(0));
    rise_n     = '0;
    fall_n     = '0;
    // A record written this cycle becomes the head only when it lands in the slot rd_ptr moves to
    if (valid_n) begin
      if (push && (rd_ptr_n == wr_ptr)) begin
        rise_n = rise;
        fall_n = fall;
      end else begin
        rise_n = mem[rd_ptr_n][REC_W-1:WIDTH];
        fall_n = mem[rd_ptr_n][WIDTH-1:0];
      end
    end
    if (drop) begin
      overflow_n = 1'b1;
    end else if (ovf_clr) begin
      overflow_n = 1'b0;
    end else begin
      overflow_n = overflow;
    end
`ifdef EDGE_MON_DROP_CNT_EN
    if (drop) begin
      if (ovf_clr) begin
        drop_cnt_n = 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt_n = drop_cnt + 8'd1;
      end else begin
        drop_cnt_n = drop_cnt;
      end
    end else if (ovf_clr) begin
      drop_cnt_n = 8'd0;
    end else begin
      drop_cnt_n = drop_cnt;
    end
`endif
  end

  // State and output registers; reset overrides push, pop and ovf_clr
  always_ff @(posedge clock) begin
    if (reset) begin
      prev      <= '0;
      armed     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      evt_valid <= 1'b0;
      evt_rise  <= '0;
      evt_fall  <= '0;
      overflow  <= 1'b0;
`ifdef EDGE_MON_DROP_CNT_EN
      drop_cnt  <= 8'd0;
`endif
    end else begin
      prev      <= sig_in;
      armed     <= 1'b1;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      occupancy <= count_n;
      evt_valid <= valid_n;
      evt_rise  <= rise_n;
      evt_fall  <= fall_n;
      overflow  <= overflow_n;
`ifdef EDGE_MON_DROP_CNT_EN
      drop_cnt  <= drop_cnt_n;
`endif
    end
  end

  // Record storage; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr] <= rec;
    end
  end

endmodule

// File: tb/tb_edge_event_monitor.sv
// Scoreboard bench for edge_event_monitor: directed scenarios then random traffic against a queue-based model.
module tb_edge_event_monitor;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] sig_in = '0;
  logic             evt_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             evt_valid;
  logic [WIDTH-1:0] evt_rise, evt_fall;
  logic [$clog2(DEPTH):0] occupancy;
  logic             overflow;
`ifdef EDGE_MON_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  edge_event_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .sig_in    (sig_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_rise  (evt_rise),
    .evt_fall  (evt_fall),
    .occupancy (occupancy),
    .ovf_clr   (ovf_clr),
    .overflow  (overflow)
`ifdef EDGE_MON_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference model: records the consumer should receive, in order
  logic [2*WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0]   m_prev = '0;
  bit                 m_armed = 1'b0;
  int                 m_cnt = 0;
  bit                 m_ovf = 1'b0;
  int                 m_drops = 0;
  bit                 m_known = 1'b0;
  logic [WIDTH-1:0]   cur = '0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Verify state left by the previous edge, drive the next cycle, advance the model
  task automatic step(input bit r, input bit e, input logic [WIDTH-1:0] s, input bit rd, input bit c);
    logic [WIDTH-1:0] rise, fall;
    bit pop, dropped;
    @(negedge clock);
    #1;
    if (m_known) begin
      check("occupancy", int'(occupancy), m_cnt);
      check("evt_valid", int'(evt_valid), int'(m_cnt > 0));
      check("overflow", int'(overflow), int'(m_ovf));
`ifdef EDGE_MON_DROP_CNT_EN
      check("drop_cnt", int'(drop_cnt), m_drops);
`endif
    end
    reset = r; en = e; sig_in = s; evt_ready = rd; ovf_clr = c;
    if (r) begin
      exp_q.delete();
      m_prev = '0; m_armed = 1'b0; m_cnt = 0; m_ovf = 1'b0; m_drops = 0;
      m_known = 1'b1;
    end else begin
      rise = s & ~m_prev;
      fall = ~s & m_prev;
      pop = (m_cnt > 0) && rd;
      dropped = 1'b0;
      if (m_armed && e && ((rise | fall) != '0)) begin
        if ((m_cnt < DEPTH) || pop) begin
          exp_q.push_back({rise, fall});
          m_cnt++;
        end else begin
          dropped = 1'b1;
        end
      end
      if (pop) m_cnt--;
      if (dropped) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (dropped) m_drops = c ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      else if (c) m_drops = 0;
      m_prev = s;
      m_armed = 1'b1;
    end
  endtask

  // Monitor: consume records at each handshake and compare with the scoreboard
  initial begin
    logic [2*WIDTH-1:0] exp;
    forever begin
      @(negedge clock);
      #3;
      if (m_known && !reset) begin
        if (evt_valid && evt_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_record: got rise=%b fall=%b expected none", evt_rise, evt_fall);
          end else begin
            exp = exp_q.pop_front();
            check("evt_rise", int'(evt_rise), int'(exp[2*WIDTH-1:WIDTH]));
            check("evt_fall", int'(evt_fall), int'(exp[WIDTH-1:0]));
          end
        end else if (!evt_valid) begin
          check("idle_rise", int'(evt_rise), 0);
          check("idle_fall", int'(evt_fall), 0);
        end
      end
    end
  end

  task automatic fresh(input logic [WIDTH-1:0] s);
    cur = s;
    step(1, 1, cur, 0, 0);
    step(0, 1, cur, 0, 0);
  endtask

  initial begin
    // Held pattern right after reset is only an arming load
    cur = 4'b0101;
    step(1, 1, cur, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, cur, 0, 0);

    // Two-bit rising edge held at the head
    fresh('0);
    cur = 4'b0011;
    for (int i = 0; i < 3; i++) step(0, 1, cur, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, cur, 1, 0);

    // Five toggles into a depth-4 FIFO, then drain in order
    fresh('0);
    for (int i = 0; i < 5; i++) begin cur[0] = ~cur[0]; step(0, 1, cur, 0, 0); end
    for (int i = 0; i < 6; i++) step(0, 0, cur, 1, 0);

    // Full FIFO with a push and pop in the same cycle
    fresh('0);
    for (int i = 0; i < 4; i++) begin cur[0] = ~cur[0]; step(0, 1, cur, 0, 0); end
    cur[1] = ~cur[1];
    step(0, 1, cur, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, cur, 1, 0);

    // Edges while disabled are discarded; drop with simultaneous ovf_clr keeps overflow
    fresh('0);
    for (int i = 0; i < 3; i++) begin cur[2] = ~cur[2]; step(0, 0, cur, 0, 0); end
    for (int i = 0; i < 3; i++) step(0, 1, cur, 0, 0);
    for (int i = 0; i < 4; i++) begin cur[0] = ~cur[0]; step(0, 1, cur, 0, 0); end
    cur[3] = ~cur[3];
    step(0, 1, cur, 0, 1);
    step(0, 1, cur, 0, 0);
    step(0, 1, cur, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, cur, 1, 0);

    // Reset mid-operation with an edge in the same cycle
    fresh('0);
    for (int i = 0; i < 3; i++) begin cur[1] = ~cur[1]; step(0, 1, cur, 0, 0); end
    cur[0] = ~cur[0];
    step(1, 1, cur, 1, 1);
    step(0, 1, cur, 0, 0);
    step(0, 1, cur, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cur = cur ^ WIDTH'($urandom & $urandom);
      step($urandom_range(63, 0) == 0, $urandom_range(3, 0) != 0, cur,
           $urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0);
    end

    for (int i = 0; i < DEPTH + 3; i++) step(0, 0, cur, 1, 0);
    step(0, 0, cur, 0, 0);
    check("leftover_records", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
